// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into SETUP/ACCESS transfers,
// honours PREADY wait states and aborts hung transfers with a wait-state watchdog.
module apb_master_bridge #(
  parameter int SEL_BIT = 12,
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [1:0]  PSEL,
  output logic        PENABLE,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam bit              WDOG_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [TO_W-1:0] wait_cnt;

  // Read data is only passed through for clean reads; writes and errors return zero.
  function automatic logic [31:0] gate_rdata(input logic wr, input logic err,
                                             input logic [31:0] data);
    return (wr || err) ? 32'd0 : data;
  endfunction

  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 2'b00;
      PENABLE     <= 1'b0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PWRITE  <= cmd_write;
            PPROT   <= cmd_prot;
            PSEL    <= cmd_addr[SEL_BIT] ? 2'b10 : 2'b01;
            PENABLE <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= gate_rdata(PWRITE, PSLVERR, PRDATA);
            PSEL        <= 2'b00;
            PENABLE     <= 1'b0;
            state       <= ST_IDLE;
          end else if (WDOG_EN && (wait_cnt == TO_LAST)) begin
            // Slave never answered: release the bus and report a timeout error.
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= 32'd0;
            PSEL        <= 2'b00;
            PENABLE     <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        default: begin
          PSEL    <= 2'b00;
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (bus master) for the peripheral subsystem. It is the initiator end of the bus served by the GPIO and UART APB slaves.
- Accepts single read/write commands on a valid/ready command port and runs a standard two-phase APB transfer (SETUP then ACCESS). It honours PREADY wait states and returns read data plus error status on a one-cycle response strobe.
- Includes a wait-state timeout watchdog, so a hung slave cannot stall the requester forever.

Parameters:
- SEL_BIT, 12: address bit that selects the slave. 0 -> PSEL=2'b01 (GPIO); 1 -> PSEL=2'b10 (UART).
- TIMEOUT, 256: maximum consecutive ACCESS cycles with PREADY=0 before abort. 0 disables the watchdog.
- TO_W, 16: width of the wait-state counter. TIMEOUT must be less than 2^TO_W.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  target address
- cmd_wdata  in  32  write data
- cmd_prot  in  3  protection attributes, forwarded to PPROT
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data (0 for writes, errors and timeouts)
- rsp_err  out  1  PSLVERR or timeout occurred
- rsp_timeout  out  1  transfer aborted by watchdog
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  2  one-hot slave select
- PENABLE  out  1  APB access phase
- PPROT  out  3  APB protection
- PRDATA  in  32  slave read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

Behaviour:
- Clocking/reset: one clock, PCLK. PRESETn is asynchronous and active-low.
- Reset values:
  - state=IDLE, cmd_ready=1.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PPROT=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register cmd_addr, cmd_wdata, cmd_write and cmd_prot into PADDR, PWDATA, PWRITE and PPROT.
  - Drive PSEL from cmd_addr[SEL_BIT], PENABLE=0, go to SETUP.
  - cmd_ready deasserts the cycle after acceptance.
- SETUP: lasts exactly one cycle. PENABLE<=1, clear wait counter, go to ACCESS.
- ACCESS: PADDR, PWDATA, PWRITE, PSEL and PPROT are held stable.
  - PREADY=1: transfer completes. Next cycle:
    - rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0.
    - rsp_rdata=PRDATA if read and !PSLVERR, else 0.
    - PSEL=0, PENABLE=0, state=IDLE, cmd_ready=1.
  - PREADY=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort. Next cycle:
    - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - PSEL=0, PENABLE=0, state=IDLE.
  - Otherwise: counter+1, stay in ACCESS.
- Response fields:
  - rsp_valid is high for exactly one cycle per accepted command.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- Back-to-back: a new command can be accepted in the same cycle rsp_valid is high, because the bridge is in IDLE then. Minimum of 3 cycles per transfer (accept, SETUP, ACCESS).
- cmd_valid outside IDLE: ignored, no effect; cmd_ready=0.
- PADDR, PWDATA and PPROT keep their last values in IDLE. PSEL=0 makes them don't-care.
- PRDATA, PREADY and PSLVERR are sampled only in ACCESS; other states ignore them.
- Reset mid-transfer: asynchronously forces the reset values. No response is issued for the aborted command.

Test Plan:
- Write, no wait:
  - Stimulus: cmd write addr=0x0000_0004, wdata=0xA5; PREADY tied 1.
  - Required: PSEL=01 in SETUP and ACCESS, PENABLE only in ACCESS, PWDATA=0xA5.
  - Required: rsp_valid 3 cycles after accept, rsp_err=0.
- Read with waits:
  - Stimulus: read addr=0x0000_1008; PREADY low 2 ACCESS cycles, then high with PRDATA=0x3C.
  - Required: PSEL=10, ACCESS lasts 3 cycles, rsp_rdata=0x3C.
  - Required: PADDR stable throughout SETUP and ACCESS.
- Slave error:
  - Stimulus: read with PREADY=1, PSLVERR=1, PRDATA=0xFF.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=4, PREADY held 0.
  - Required: after 4 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_timeout=1; PSEL=0; cmd_ready=1.
  - Repeat with TIMEOUT=0: bridge stays in ACCESS indefinitely.
- Back-to-back and ignored command:
  - Stimulus: two commands with cmd_valid held high continuously.
  - Required: second accepted on the first command's rsp_valid cycle; cmd_valid during SETUP/ACCESS causes no extra transfer.
- Reset mid-ACCESS:
  - Stimulus: assert PRESETn=0 asynchronously during a wait state.
  - Required: PSEL, PENABLE and rsp_valid drop immediately; cmd_ready=1 after release; no response for the killed command.
